// File: rtl/tru_nbit_serial.sv
// Digit-serial subtractor: D = A - B - bin over WIDTH bits, DIGIT bits per clock,
// with start/busy/done handshake and registered borrow-out, overflow and zero flags.
module tru_nbit_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res;
  logic             a_msb, b_msb, borrow;
  logic [CW-1:0]    cnt;

  logic             accept_c, last_c, ovf_c;
  logic [DIGIT:0]   diff_c;
  logic [WIDTH-1:0] res_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the single-digit ripple
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = (cnt == CW'(NDIG - 1));
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept_c  = 1'b1;
      end
      RUN:  if (last_c) state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept_c  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Operands shift right so the active digit is always at the bottom;
    // result digits enter from the top and land in place after NDIG shifts.
    diff_c = {1'b0, opa[DIGIT-1:0]} - {1'b0, opb[DIGIT-1:0]} - (DIGIT+1)'(borrow);
    res_c  = (res >> DIGIT) | (WIDTH'(diff_c[DIGIT-1:0]) << (WIDTH - DIGIT));
    ovf_c  = (a_msb != b_msb) & (res_c[WIDTH-1] != a_msb);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bo     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (accept_c) begin
        opa    <= a;
        opb    <= b;
        borrow <= bin;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        cnt    <= '0;
        res    <= '0;
      end else if (state == RUN) begin
        opa    <= opa >> DIGIT;
        opb    <= opb >> DIGIT;
        res    <= res_c;
        borrow <= diff_c[DIGIT];
        cnt    <= cnt + CW'(1);
        if (last_c) begin
          d    <= res_c;
          bo   <= diff_c[DIGIT];
          ovf  <= ovf_c;
          zero <= (res_c == '0);
        end
      end
    end
  end

endmodule
